// File: rtl/seg_scan_ctrl_if.sv
// Bundles the load/value/blank inputs and the display drive outputs of seg_scan_ctrl.
// The slave modport is the controller; the master modport is whatever feeds it and watches it.
interface seg_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     blank;
  logic [6:0]            seg;
  logic [DIGITS-1:0]     an;
  logic                  pending;
  logic                  frame;

  modport slave (
    input  load, value, blank,
    output seg, an, pending, frame
  );

  modport master (
    output load, value, blank,
    input  seg, an, pending, frame
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display with frame-atomic updates.
// Optional build macro SEG_LZ_BLANK_EN enables leading-zero suppression on the committed value.
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 50000,
  parameter int GUARD  = 2
) (
  input  logic                clk,
  input  logic                rst,
  seg_scan_ctrl_if.slave      bus,
  output logic                dbg_phase
);
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int DIG_W  = $clog2(DIGITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIV - 1);
  localparam logic [TICK_W-1:0] TICK_GRD  = TICK_W'(GUARD);
  localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(DIGITS - 1);

  // Handshake: load is a one-cycle strobe with no back-pressure; every load is accepted
  // into the shadow register, and pending stays high until that value is committed.
  typedef enum logic {
    PH_GUARD = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  phase_e                phase_q, phase_d;
  logic [TICK_W-1:0]     tick_q, tick_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   active_q, active_d;
  logic                  pending_q, pending_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  frame_q, frame_d;

  logic                  tick_wrap;
  logic                  boundary;
  logic [3:0]            act_nib;
  logic                  blank_cur;
  logic [DIGITS-1:0]     lz_mask;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h18;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  // Leading-zero mask: bit i set when nibbles i..DIGITS-1 of the committed value are all zero.
  always_comb begin
    logic upper_zero;
    lz_mask    = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero & (active_q[4*i +: 4] == 4'h0);
`ifdef SEG_LZ_BLANK_EN
      lz_mask[i] = upper_zero;
`else
      lz_mask[i] = 1'b0;
`endif
    end
  end

  always_comb begin
    act_nib   = 4'h0;
    blank_cur = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_q == DIG_W'(i)) begin
        act_nib   = active_q[4*i +: 4];
        blank_cur = bus.blank[i] | lz_mask[i];
      end
    end
  end

  always_comb begin
    tick_d    = tick_q + 1'b1;
    digit_d   = digit_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    seg_d     = 7'h7F;
    an_d      = '1;
    frame_d   = 1'b0;

    tick_wrap = (tick_q == TICK_LAST);
    boundary  = tick_wrap && (digit_q == DIG_LAST);

    if (tick_wrap) begin
      tick_d  = '0;
      digit_d = (digit_q == DIG_LAST) ? '0 : digit_q + 1'b1;
    end

    // A boundary commit always takes the pre-edge shadow; a coincident load re-arms pending.
    if (boundary && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (bus.load) begin
      shadow_d  = bus.value;
      pending_d = 1'b1;
    end

    phase_d = (tick_d < TICK_GRD) ? PH_GUARD : PH_DRIVE;

    if (phase_q == PH_DRIVE) begin
      for (int i = 0; i < DIGITS; i++) begin
        an_d[i] = (digit_q != DIG_W'(i));
      end
      seg_d = blank_cur ? 7'h7F : hex7(act_nib);
    end

    frame_d = (tick_q == '0) && (digit_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= PH_GUARD;
      tick_q    <= '0;
      digit_q   <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= 7'h7F;
      an_q      <= '1;
      frame_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      tick_q    <= tick_d;
      digit_q   <= digit_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
  assign bus.pending = pending_q;
  assign bus.frame   = frame_q;
  assign dbg_phase   = phase_q;
endmodule
